// File: rtl/dcm_lock_ctrl.sv
// dcm_lock_ctrl: sequences DCM reset and lock acquisition, releasing user reset once lock is stable
module dcm_lock_ctrl #(
  parameter int RST_CYCLES    = 8,
  parameter int LOCK_TIMEOUT  = 65535,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRY     = 7,
  parameter int SYNC_STAGES   = 2
) (
  input  logic       BUS_CLK,
  input  logic       BUS_RST_N,
  input  logic       DCM_LOCKED,
  input  logic       CLK_STOPPED,
  input  logic       SOFT_RST,
  output logic       DCM_RST,
  output logic       USER_RST,
  output logic       READY,
  output logic       FAIL,
  output logic [3:0] RETRY_CNT,
  output logic [7:0] RELOCK_CNT,
  output logic [2:0] STATE
);
  localparam int M1 = RST_CYCLES > LOCK_TIMEOUT ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int CW = $clog2(M1 > STABLE_CYCLES ? M1 : STABLE_CYCLES);
  typedef enum logic [2:0] {
    RESET     = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAILED    = 3'd4
  } state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [3:0] retry_nxt;
  logic [7:0] relock_nxt;
  logic [SYNC_STAGES-1:0] lk_sync, cs_sync;
  logic lk, cs, lost;
  assign lk    = lk_sync[SYNC_STAGES-1];
  assign cs    = cs_sync[SYNC_STAGES-1];
  assign lost  = !lk || cs;
  assign STATE = state;
  always_comb begin
    nxt        = state;
    cnt_nxt    = cnt + CW'(1);
    retry_nxt  = RETRY_CNT;
    relock_nxt = RELOCK_CNT;
    if (SOFT_RST) begin
      nxt       = RESET;
      cnt_nxt   = '0;
      retry_nxt = '0;
    end else begin
      case (state)
        RESET: begin
          if (cnt == CW'(RST_CYCLES - 1)) begin
            nxt     = WAIT_LOCK;
            cnt_nxt = '0;
          end
        end
        WAIT_LOCK: begin
          if (lk) begin
            nxt     = STABLE;
            cnt_nxt = '0;
          end else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
            retry_nxt = RETRY_CNT + 4'd1;
            nxt       = (RETRY_CNT == 4'(MAX_RETRY - 1)) ? FAILED : RESET;
            cnt_nxt   = '0;
          end
        end
        STABLE: begin
          if (lost) begin
            nxt     = WAIT_LOCK;
            cnt_nxt = '0;
          end else if (cnt == CW'(STABLE_CYCLES - 1)) begin
            nxt     = RUN;
            cnt_nxt = '0;
          end
        end
        RUN: begin
          cnt_nxt = '0;
          if (lost) begin
            nxt        = RESET;
            retry_nxt  = '0;
            relock_nxt = (&RELOCK_CNT) ? RELOCK_CNT : RELOCK_CNT + 8'd1;
          end
        end
        FAILED:  cnt_nxt = '0;
        default: begin
          nxt     = RESET;
          cnt_nxt = '0;
        end
      endcase
    end
  end
  always_ff @(posedge BUS_CLK) begin
    if (!BUS_RST_N) begin
      state      <= RESET;
      cnt        <= '0;
      RETRY_CNT  <= '0;
      RELOCK_CNT <= '0;
      lk_sync    <= '0;
      cs_sync    <= '0;
      DCM_RST    <= 1'b1;
      USER_RST   <= 1'b1;
      READY      <= 1'b0;
      FAIL       <= 1'b0;
    end else begin
      state      <= nxt;
      cnt        <= cnt_nxt;
      RETRY_CNT  <= retry_nxt;
      RELOCK_CNT <= relock_nxt;
      lk_sync    <= {lk_sync[SYNC_STAGES-2:0], DCM_LOCKED};
      cs_sync    <= {cs_sync[SYNC_STAGES-2:0], CLK_STOPPED};
      DCM_RST    <= nxt == RESET;
      USER_RST   <= nxt != RUN;
      READY      <= nxt == RUN;
      FAIL       <= nxt == FAILED;
    end
  end
endmodule
